// File: rtl/mult_signed_pipe.sv
// mult_signed_pipe: pipelined signed x signed multiplier with valid/ready flow control.
// Sign-magnitude core: stage 1 takes operand magnitudes, $clog2(B_W) registered adder-tree
// levels sum the partial products, and the final stage restores the sign.
// Latency is $clog2(B_W)+2 cycles. The whole pipeline stalls together when the output is
// valid and not taken.
// Optional feature: define MULT_SAT_EN to clip the product to OUT_W signed bits and flag it on sat.
module mult_signed_pipe #(
  parameter int unsigned A_W   = 11,
  parameter int unsigned B_W   = 8,
  parameter int unsigned OUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef MULT_SAT_EN
  output logic [OUT_W-1:0]     p,
`else
  output logic [A_W+B_W-1:0]   p,
`endif
  output logic                 sat
);

  localparam int unsigned P_W = A_W + B_W;
  localparam int unsigned LVL = $clog2(B_W);

  // Global advance: every stage moves together or holds together.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1 operand magnitudes; the most negative input maps to exactly 2^(W-1).
  logic [A_W-1:0] abs_a;
  logic [B_W-1:0] abs_b;

  // Two's-complement magnitude of each operand.
  always_comb begin
    abs_a = a[A_W-1] ? (~a + A_W'(1)) : a;
    abs_b = b[B_W-1] ? (~b + B_W'(1)) : b;
  end

  logic           s1_vld;
  logic [A_W-1:0] s1_ma;
  logic [B_W-1:0] s1_mb;
  logic           s1_sign;
  logic           s1_zero;

  // Stage 1 register: magnitudes plus sign and zero flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_ma   <= '0;
      s1_mb   <= '0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
    end else if (adv) begin
      s1_vld  <= in_valid;
      s1_ma   <= abs_a;
      s1_mb   <= abs_b;
      s1_sign <= a[A_W-1] ^ b[B_W-1];
      s1_zero <= (a == '0) || (b == '0);
    end
  end

  // Partial products and the inputs of every tree level.
  // Each level source array is padded to twice B_W with zeros. Term j of a level is then
  // always src[2j]+src[2j+1], and an unpaired term passes through as term+0 with no
  // special case for odd counts.
  logic [P_W-1:0] pp     [B_W];
  logic [P_W-1:0] src    [LVL][2*B_W];
  logic [P_W-1:0] lvl_q  [LVL][B_W];
  logic           t_vld  [LVL];
  logic           t_sign [LVL];
  logic           t_zero [LVL];

  // Shifted partial products |a| & |b|[i] << i, and the per-level adder sources.
  always_comb begin
    for (int unsigned i = 0; i < B_W; i++) begin
      pp[i] = P_W'(s1_ma & {A_W{s1_mb[i]}}) << i;
    end
    for (int unsigned l = 0; l < LVL; l++) begin
      for (int unsigned j = 0; j < 2*B_W; j++) begin
        src[l][j] = '0;
      end
    end
    for (int unsigned j = 0; j < B_W; j++) begin
      src[0][j] = pp[j];
    end
    for (int unsigned l = 1; l < LVL; l++) begin
      for (int unsigned j = 0; j < B_W; j++) begin
        src[l][j] = lvl_q[l-1][j];
      end
    end
  end

  // Registered pairwise-add tree levels; valid, sign and zero travel alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned l = 0; l < LVL; l++) begin
        for (int unsigned j = 0; j < B_W; j++) begin
          lvl_q[l][j] <= '0;
        end
        t_vld[l]  <= 1'b0;
        t_sign[l] <= 1'b0;
        t_zero[l] <= 1'b0;
      end
    end else if (adv) begin
      for (int unsigned l = 0; l < LVL; l++) begin
        for (int unsigned j = 0; j < B_W; j++) begin
          lvl_q[l][j] <= src[l][2*j] + src[l][2*j+1];
        end
      end
      t_vld[0]  <= s1_vld;
      t_sign[0] <= s1_sign;
      t_zero[0] <= s1_zero;
      for (int unsigned l = 1; l < LVL; l++) begin
        t_vld[l]  <= t_vld[l-1];
        t_sign[l] <= t_sign[l-1];
        t_zero[l] <= t_zero[l-1];
      end
    end
  end

  // Sign restoration; a zero product is forced to plain 0.
  logic [P_W-1:0] mag;
  logic [P_W-1:0] res;

  // Apply the product sign to the tree magnitude.
  always_comb begin
    mag = lvl_q[LVL-1][0];
    res = mag;
    if (t_zero[LVL-1]) begin
      res = '0;
    end else if (t_sign[LVL-1]) begin
      res = ~mag + P_W'(1);
    end
  end

`ifdef MULT_SAT_EN
  localparam logic [P_W-1:0] SMAX = {{(P_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [P_W-1:0] SMIN = {{(P_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Final register with clipping to the OUT_W signed range folded in.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      p         <= '0;
      sat       <= 1'b0;
    end else if (adv) begin
      out_valid <= t_vld[LVL-1];
      if ($signed(res) > $signed(SMAX)) begin
        p   <= SMAX[OUT_W-1:0];
        sat <= 1'b1;
      end else if ($signed(res) < $signed(SMIN)) begin
        p   <= SMIN[OUT_W-1:0];
        sat <= 1'b1;
      end else begin
        p   <= res[OUT_W-1:0];
        sat <= 1'b0;
      end
    end
  end
`else
  // Final register: full-width signed product.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      p         <= '0;
    end else if (adv) begin
      out_valid <= t_vld[LVL-1];
      p         <= res;
    end
  end

  assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_mult_signed_pipe.sv
// tb_mult_signed_pipe: directed and random valid/ready vectors against a queue-based
// arithmetic model (a*b, optionally clipped), plus literal expectations for corner products.
module tb_mult_signed_pipe;

  localparam int A_W   = 11;
  localparam int B_W   = 8;
  localparam int OUT_W = 16;
  localparam int P_W   = A_W + B_W;
  localparam int LAT   = 5;
`ifdef MULT_SAT_EN
  localparam int PO_W = OUT_W;
`else
  localparam int PO_W = P_W;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [A_W-1:0]  a;
  logic [B_W-1:0]  b;
  logic            out_valid;
  logic            out_ready;
  logic [PO_W-1:0] p;
  logic            sat;

  mult_signed_pipe #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .sat(sat)
  );

  always #5 clk = ~clk;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned cyc       = 0;
  int unsigned n_out     = 0;
  bit          chk_lat   = 1'b0;

  typedef struct {
    longint      p;
    bit          s;
    int unsigned acc;
  } exp_t;

  exp_t   exp_q[$];
  longint got_q[$];
  bit     got_s_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference product: exact signed multiply, clipped when saturation is built in.
  function automatic longint model_p(input longint sa, input longint sb, output bit s);
    longint r;
    r = sa * sb;
    s = 1'b0;
`ifdef MULT_SAT_EN
    if (r > (longint'(1) <<< (OUT_W-1)) - 1) begin
      r = (longint'(1) <<< (OUT_W-1)) - 1;
      s = 1'b1;
    end else if (r < -(longint'(1) <<< (OUT_W-1))) begin
      r = -(longint'(1) <<< (OUT_W-1));
      s = 1'b1;
    end
`endif
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Compare process: inputs/outputs are stable at the falling edge and describe the
  // transfers that happen at the next rising edge.
  bit     held   = 1'b0;
  longint held_p = 0;
  always @(negedge clk) begin
    exp_t   e;
    bit     s;
    longint cur_p;
    cur_p = $signed(p);
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", longint'(out_valid), 1);
        check("hold_p", cur_p, held_p);
      end
      if (out_valid && !out_ready) check("stall_in_ready", longint'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("product", cur_p, e.p);
          check("sat_flag", longint'(sat), longint'(e.s));
          if (chk_lat) check("latency", longint'(cyc + 1 - e.acc), LAT);
          got_q.push_back(cur_p);
          got_s_q.push_back(sat);
          n_out++;
        end
      end
      held   = out_valid && !out_ready;
      held_p = cur_p;
      if (in_valid && in_ready) begin
        e.p   = model_p(longint'($signed(a)), longint'($signed(b)), s);
        e.s   = s;
        e.acc = cyc + 1;
        exp_q.push_back(e);
      end
    end
  end

  // Present one operand pair and hold it until accepted (bounded).
  task automatic send(input logic [A_W-1:0] av, input logic [B_W-1:0] bv);
    int unsigned n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", longint'(exp_q.size()), 0);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [A_W-1:0] rand_a();
    case ($urandom_range(0, 7))
      0: return {1'b1, {(A_W-1){1'b0}}};
      1: return {1'b0, {(A_W-1){1'b1}}};
      2: return '0;
      default: return A_W'($urandom);
    endcase
  endfunction

  function automatic logic [B_W-1:0] rand_b();
    case ($urandom_range(0, 7))
      0: return {1'b1, {(B_W-1){1'b0}}};
      1: return {1'b0, {(B_W-1){1'b1}}};
      2: return '0;
      default: return B_W'($urandom);
    endcase
  endfunction

  bit rand_or = 1'b0;

  initial begin
    longint      lit_p [5];
    int unsigned base;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    idle(3);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_p", longint'(p), 0);
    check("rst_sat", longint'(sat), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    rst = 1'b0;
    idle(1);

    // Corner products, each in isolation, with latency checked.
`ifdef MULT_SAT_EN
    lit_p = '{32767, 32767, -1, 0, 0};
`else
    lit_p = '{131072, 129921, -1, 0, 0};
`endif
    chk_lat = 1'b1;
    got_q.delete();
    got_s_q.delete();
    send(A_W'(-1024), B_W'(-128)); drain();
    send(A_W'(1023),  B_W'(127));  drain();
    send(A_W'(-1),    B_W'(1));    drain();
    send(A_W'(0),     B_W'(-5));   drain();
    send(A_W'(-1024), B_W'(0));    drain();
    check("corner_count", longint'(got_q.size()), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check($sformatf("corner_lit%0d", i), got_q[i], lit_p[i]);

`ifdef MULT_SAT_EN
    got_q.delete();
    got_s_q.delete();
    send(A_W'(1023),  B_W'(127)); drain();
    send(A_W'(-1024), B_W'(127)); drain();
    send(A_W'(100),   B_W'(-50)); drain();
    if (got_q.size() == 3) begin
      check("sat_hi_p", got_q[0], 32767);  check("sat_hi_s", longint'(got_s_q[0]), 1);
      check("sat_lo_p", got_q[1], -32768); check("sat_lo_s", longint'(got_s_q[1]), 1);
      check("sat_in_p", got_q[2], -5000);  check("sat_in_s", longint'(got_s_q[2]), 0);
    end else begin
      check("sat_count", longint'(got_q.size()), 3);
    end
`endif

    // Back-to-back stream of 64 random pairs.
    base = n_out;
    for (int i = 0; i < 64; i++) send(rand_a(), rand_b());
    drain();
    check("stream_count", longint'(n_out - base), 64);

    // Stream of 10 with out_ready low for 8 cycles from cycle 3.
    chk_lat = 1'b0;
    base = n_out;
    fork
      begin
        idle(3);
        out_ready = 1'b0;
        idle(8);
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 10; i++) send(rand_a(), rand_b());
    idle(12);
    drain();
    check("stall_count", longint'(n_out - base), 10);

    // Random in_valid and out_ready, 2000 pairs.
    base = n_out;
    rand_or = 1'b1;
    fork
      begin
        while (rand_or) begin
          @(posedge clk);
          #1;
          out_ready = rand_or ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 2000; i++) begin
      while ($urandom_range(0, 1) == 0) idle(1);
      send(rand_a(), rand_b());
    end
    rand_or = 1'b0;
    idle(2);
    out_ready = 1'b1;
    drain();
    check("random_count", longint'(n_out - base), 2000);

    // Reset mid-stream discards in-flight items.
    chk_lat = 1'b1;
    base = n_out;
    send(A_W'(5), B_W'(6));
    send(A_W'(7), B_W'(8));
    send(A_W'(9), B_W'(10));
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst_mid_out_valid", longint'(out_valid), 0);
    check("rst_mid_in_ready", longint'(in_ready), 1);
    idle(8);
    check("rst_mid_no_output", longint'(n_out - base), 0);
    got_q.delete();
    send(A_W'(-3), B_W'(7));
    drain();
    check("rst_after_count", longint'(n_out - base), 1);
    if (got_q.size() > 0) check("rst_after_p", got_q[0], -21);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded bound, got %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
